bram1_arbiter: RTL and testbench
================================

# bram1_arbiter

Two-requester round-robin arbiter and read-response router for one single-ported BRAM (EN/WE/ADDR/DI/DO, one access per cycle, optional output register). Each requester issues read or write commands with a combinational grant and gets its own read-response strobe when data appears on the shared DO bus. It sits between two client datapaths (for example a table loader and a lookup engine) and the BRAM instance. The arbiter owns the BRAM command port exclusively.

## Interface
- ADDR_WIDTH, 1, BRAM address width
- DATA_WIDTH, 1, BRAM data width
- PIPELINED, 0, must match the BRAM instance; 0 = read data 1 cycle after accept, 1 = 2 cycles
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- A_REQ  in  1  requester A command valid
- A_WE  in  1  1 = write, 0 = read
- A_ADDR  in  ADDR_WIDTH  command address
- A_DI  in  DATA_WIDTH  write data
- A_GNT  out  1  command accepted this cycle (combinational)
- A_RVALID  out  1  read data for A valid on A_RDATA this cycle
- A_RDATA  out  DATA_WIDTH  read data (always driven from BRAM_DO)
- B_REQ, B_WE, B_ADDR, B_DI, B_GNT, B_RVALID, B_RDATA: same as A for requester B
- BRAM_EN  out  1  BRAM enable
- BRAM_WE  out  1  BRAM write enable
- BRAM_ADDR  out  ADDR_WIDTH  BRAM address
- BRAM_DI  out  DATA_WIDTH  BRAM write data
- BRAM_DO  in  DATA_WIDTH  BRAM read data

## Operation
- Command accepted when X_REQ && X_GNT at posedge. Requester holds REQ/WE/ADDR/DI stable until granted; no withdrawal rule is checked.
- Grant, combinational: RST=1 gives no grants. One REQ gives that requester the grant. Both REQ give the grant to the side named by priority pointer PRI (0 = A, 1 = B). At most one GNT per cycle.
- PRI register: reset 0. On every accepted command PRI <= ~winner (winner A gives PRI=1). No grant leaves PRI unchanged. Under continuous contention grants alternate A,B,A,B.
- BRAM_EN = A_GNT | B_GNT. BRAM_WE/ADDR/DI are muxed from the winner. When EN=0, ADDR/DI/WE hold the A inputs and WE is forced 0.
- Writes produce no response.
- Reads push a tag {valid, id} into a tag pipeline, 1 stage if PIPELINED=0 and 2 stages if 1. Stages shift every cycle. An empty cycle inserts valid=0.
- X_RVALID = last-stage valid && id==X. At most one RVALID per cycle. No backpressure: the client must consume on the strobe.
- A_RDATA = B_RDATA = BRAM_DO.
- A write followed by a read of the same address in the next accepted cycle returns the new data (BRAM write-first on the array).

## Timing
- Reset values while and after RST: A_GNT=B_GNT=0, BRAM_EN=0, BRAM_WE=0, A_RVALID=B_RVALID=0, PRI=0, all tag stages invalid.
- Read accepted at edge N: RVALID high in cycle N+1 (PIPELINED=0) or N+2 (PIPELINED=1), for exactly one cycle.
- Throughput: one command per cycle total, back-to-back reads give back-to-back RVALIDs in accept order.
- Reset asserted mid-flight: all in-flight tags are dropped, and no RVALID appears in any cycle after the reset edge. The first grant is possible in the cycle RST deasserts.
- Simultaneous write by one side and read by the other is impossible (one grant per cycle). The loser waits with no loss.

## Test plan
- Reset mid-read, PIPELINED=1: A read accepted at N, RST=1 at edge N+1 -> no A_RVALID at N+2. PRI=0, all outputs 0.
- Single requester, PIPELINED=0: A writes 0x5A to addr 3, then reads addr 3 -> A_GNT both cycles. A_RVALID one cycle after the read accept, A_RDATA=0x5A, B_RVALID never set.
- Contention from reset: A and B both request reads continuously for 6 cycles -> grant order A,B,A,B,A,B. RVALID strobes follow the same order, one cycle later (PIPELINED=0) or two cycles later (PIPELINED=1).
- Pointer update: B alone granted once, then both request -> A wins (PRI=0 after a B grant). Next contention cycle B wins.
- Read-after-write race: B writes 0x11 to addr 7 at N, A reads addr 7 at N+1 -> A_RDATA=0x11 on A_RVALID.
- Idle/write-only traffic: 10 cycles of writes alternating A/B with no reads -> A_RVALID=B_RVALID=0 throughout. BRAM_WE=1 on every granted cycle, BRAM_EN=0 on idle cycles.

Source files
------------

// File: rtl/bram1_arbiter_if.sv
// One requester's command/response channel into the shared BRAM arbiter.
// The client side uses master, the arbiter side uses slave.
interface bram1_arbiter_if #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] di;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, di,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, di,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/bram1_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-ported BRAM,
// with a tag pipeline that routes each read response back to its issuer.
module bram1_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter bit PIPELINED  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    bram1_arbiter_if.slave        a,
    bram1_arbiter_if.slave        b,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);
    // Read latency of the BRAM instance, in cycles after the accept edge.
    localparam int STAGES = PIPELINED ? 2 : 1;

    logic pri_reg;
    logic pri_next;
    logic gnt_a;
    logic gnt_b;

    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] id_reg;
    logic [STAGES-1:0] id_next;
    logic              head_valid;
    logic              head_id;

    // Grant: pri_reg names the side that wins a tie (0 = A, 1 = B).
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (a.req && (!b.req || !pri_reg)) begin
                gnt_a = 1'b1;
            end else if (b.req) begin
                gnt_b = 1'b1;
            end
        end
    end

    always_comb begin
        pri_next = pri_reg;
        if (gnt_a) begin
            pri_next = 1'b1;
        end else if (gnt_b) begin
            pri_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pri_reg <= 1'b0;
        end else begin
            pri_reg <= pri_next;
        end
    end

    assign a.gnt = gnt_a;
    assign b.gnt = gnt_b;

    // Idle cycles park the address/data mux on A with the write strobe off.
    assign bram_en   = gnt_a | gnt_b;
    assign bram_we   = gnt_b ? b.we   : (gnt_a & a.we);
    assign bram_addr = gnt_b ? b.addr : a.addr;
    assign bram_di   = gnt_b ? b.di   : a.di;

    assign head_valid = (gnt_a & ~a.we) | (gnt_b & ~b.we);
    assign head_id    = gnt_b;

    // Tag pipeline: stage 0 takes the accepted read, later stages shift.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_tag
        if (gi == 0) begin : g_head
            assign valid_next[gi] = head_valid;
            assign id_next[gi]    = head_id;
        end else begin : g_shift
            assign valid_next[gi] = valid_reg[gi-1];
            assign id_next[gi]    = id_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            id_reg    <= '0;
        end else begin
            valid_reg <= valid_next;
            id_reg    <= id_next;
        end
    end

    assign a.rvalid = !rst && valid_reg[STAGES-1] && !id_reg[STAGES-1];
    assign b.rvalid = !rst && valid_reg[STAGES-1] &&  id_reg[STAGES-1];
    assign a.rdata  = bram_do;
    assign b.rdata  = bram_do;
endmodule

// File: tb/tb_bram1_arbiter.sv
// Drives two arbiter instances (PIPELINED 0 and 1) with identical traffic and
// checks both against a rule-level model of grants, memory and response timing.
module tb_bram1_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_di = '0, b_di = '0;

    bram1_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a0_if ();
    bram1_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0_if ();
    bram1_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) a1_if ();
    bram1_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1_if ();

    assign a0_if.req = a_req;  assign a0_if.we = a_we;  assign a0_if.addr = a_addr;  assign a0_if.di = a_di;
    assign b0_if.req = b_req;  assign b0_if.we = b_we;  assign b0_if.addr = b_addr;  assign b0_if.di = b_di;
    assign a1_if.req = a_req;  assign a1_if.we = a_we;  assign a1_if.addr = a_addr;  assign a1_if.di = a_di;
    assign b1_if.req = b_req;  assign b1_if.we = b_we;  assign b1_if.addr = b_addr;  assign b1_if.di = b_di;

    logic          bram0_en, bram0_we, bram1_en, bram1_we;
    logic [AW-1:0] bram0_addr, bram1_addr;
    logic [DW-1:0] bram0_di, bram1_di, bram0_do, bram1_do;

    bram1_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .a(a0_if.slave), .b(b0_if.slave),
        .bram_en(bram0_en), .bram_we(bram0_we), .bram_addr(bram0_addr),
        .bram_di(bram0_di), .bram_do(bram0_do)
    );

    bram1_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1'b1)) dut1 (
        .clk(clk), .rst(rst), .a(a1_if.slave), .b(b1_if.slave),
        .bram_en(bram1_en), .bram_we(bram1_we), .bram_addr(bram1_addr),
        .bram_di(bram1_di), .bram_do(bram1_do)
    );

    // Write-first BRAM instances; the second has an extra output register.
    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] do0_reg, do1_reg, do1_out_reg;

    always @(posedge clk) begin
        if (bram0_en) begin
            if (bram0_we) begin
                mem0[bram0_addr] <= bram0_di;
                do0_reg <= bram0_di;
            end else begin
                do0_reg <= mem0[bram0_addr];
            end
        end
        if (bram1_en) begin
            if (bram1_we) begin
                mem1[bram1_addr] <= bram1_di;
                do1_reg <= bram1_di;
            end else begin
                do1_reg <= mem1[bram1_addr];
            end
        end
        do1_out_reg <= do1_reg;
    end
    assign bram0_do = do0_reg;
    assign bram1_do = do1_out_reg;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant rule, memory contents, responses keyed by due cycle.
    int            cyc = 0;
    bit            model_pri = 1'b0;
    logic [DW-1:0] ref_mem [16];
    bit            ev   [2][4];
    bit            eid  [2][4];
    logic [DW-1:0] edat [2][4];

    always @(negedge clk) begin
        bit            eg_a, eg_b, en, we, xa, xb;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        int            s;
        eg_a = !rst && a_req && (!b_req || !model_pri);
        eg_b = !rst && b_req && !eg_a;
        en   = eg_a || eg_b;
        we   = eg_b ? b_we : (eg_a ? a_we : 1'b0);
        addr = eg_b ? b_addr : a_addr;
        di   = eg_b ? b_di : a_di;
        s    = cyc % 4;

        chk("gnt0", {a0_if.gnt, b0_if.gnt}, {eg_a, eg_b});
        chk("gnt1", {a1_if.gnt, b1_if.gnt}, {eg_a, eg_b});
        chk("bram0_cmd", {bram0_en, bram0_we, bram0_addr, bram0_di}, {en, we, addr, di});
        chk("bram1_cmd", {bram1_en, bram1_we, bram1_addr, bram1_di}, {en, we, addr, di});

        xa = !rst && ev[0][s] && !eid[0][s];
        xb = !rst && ev[0][s] &&  eid[0][s];
        chk("rvalid0", {a0_if.rvalid, b0_if.rvalid}, {xa, xb});
        if (xa) chk("rdata_a0", a0_if.rdata, edat[0][s]);
        if (xb) chk("rdata_b0", b0_if.rdata, edat[0][s]);

        xa = !rst && ev[1][s] && !eid[1][s];
        xb = !rst && ev[1][s] &&  eid[1][s];
        chk("rvalid1", {a1_if.rvalid, b1_if.rvalid}, {xa, xb});
        if (xa) chk("rdata_a1", a1_if.rdata, edat[1][s]);
        if (xb) chk("rdata_b1", b1_if.rdata, edat[1][s]);

        ev[0][s] = 1'b0;
        ev[1][s] = 1'b0;
        if (rst) begin
            model_pri = 1'b0;
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < 4; k++) ev[p][k] = 1'b0;
        end else if (en) begin
            if (we) begin
                ref_mem[addr] = di;
            end else begin
                ev[0][(cyc + 1) % 4] = 1'b1;  eid[0][(cyc + 1) % 4] = eg_b;  edat[0][(cyc + 1) % 4] = ref_mem[addr];
                ev[1][(cyc + 2) % 4] = 1'b1;  eid[1][(cyc + 2) % 4] = eg_b;  edat[1][(cyc + 2) % 4] = ref_mem[addr];
            end
            model_pri = eg_a;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] di);
        a_req = req; a_we = we; a_addr = addr; a_di = di;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] di);
        b_req = req; b_we = we; b_addr = addr; b_di = di;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] order;
        int         cnt, rv_cnt, we_cnt, idle_cnt;
        bit         ga, gb;

        for (int k = 0; k < 16; k++) begin
            mem0[k] = '0; mem1[k] = '0; ref_mem[k] = '0;
        end

        // Reset with both requesting: nothing may be granted or strobed.
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0);
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("reset_outputs", {a0_if.gnt, b0_if.gnt, bram0_en, bram0_we, a0_if.rvalid, b0_if.rvalid,
                              a1_if.gnt, b1_if.gnt, bram1_en, bram1_we, a1_if.rvalid, b1_if.rvalid}, 0);
        tick();
        rst = 1'b0;

        // Single requester: write 0x5A to 3, read it back.
        set_a(1, 1, 3, 8'h5A);
        set_b(0, 0, 0, 0);
        @(negedge clk); chk("single_wr_gnt", a0_if.gnt, 1);
        tick();
        set_a(1, 0, 3, 0);
        @(negedge clk); chk("single_rd_gnt", a0_if.gnt, 1);
        tick();
        set_a(0, 0, 0, 0);
        @(negedge clk);
        chk("single_p0_rvalid", {a0_if.rvalid, b0_if.rvalid}, 2'b10);
        chk("single_p0_rdata", a0_if.rdata, 8'h5A);
        chk("single_p1_early", {a1_if.rvalid, b1_if.rvalid}, 2'b00);
        tick();
        @(negedge clk);
        chk("single_p1_rvalid", {a1_if.rvalid, b1_if.rvalid}, 2'b10);
        chk("single_p1_rdata", a1_if.rdata, 8'h5A);
        tick();

        // Contention from reset: A,B,A,B,A,B.
        do_reset();
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0);
        order = '0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            order = {order[4:0], b0_if.gnt};
            cnt += int'(a0_if.gnt ^ b0_if.gnt);
            tick();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        chk("contention_order", order, 6'b010101);
        chk("contention_grants", cnt, 6);
        tick(); tick();

        // Pointer: B alone once, then both -> A, then B.
        do_reset();
        set_b(1, 0, 5, 0);
        @(negedge clk); chk("ptr_b_alone", {a0_if.gnt, b0_if.gnt}, 2'b01);
        tick();
        set_a(1, 0, 6, 0);
        @(negedge clk); chk("ptr_a_wins", {a0_if.gnt, b0_if.gnt}, 2'b10);
        tick();
        @(negedge clk); chk("ptr_b_wins", {a0_if.gnt, b0_if.gnt}, 2'b01);
        tick();
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        tick(); tick();

        // Read-after-write across requesters.
        set_b(1, 1, 7, 8'h11);
        @(negedge clk); chk("raw_b_wr_gnt", b0_if.gnt, 1);
        tick();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 7, 0);
        @(negedge clk); chk("raw_a_rd_gnt", a0_if.gnt, 1);
        tick();
        set_a(0, 0, 0, 0);
        @(negedge clk);
        chk("raw_p0_rvalid", a0_if.rvalid, 1);
        chk("raw_p0_rdata", a0_if.rdata, 8'h11);
        tick();
        @(negedge clk);
        chk("raw_p1_rvalid", a1_if.rvalid, 1);
        chk("raw_p1_rdata", a1_if.rdata, 8'h11);
        tick();

        // Write-only traffic with idle gaps.
        rv_cnt = 0; we_cnt = 0; idle_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            set_a(0, 0, 0, 0);
            set_b(0, 0, 0, 0);
            if (i % 5 != 4) begin
                if (i % 2 == 0) set_a(1, 1, AW'(i), DW'(8'h30 + i));
                else            set_b(1, 1, AW'(i), DW'(8'h40 + i));
            end
            @(negedge clk);
            rv_cnt   += int'(a0_if.rvalid) + int'(b0_if.rvalid) + int'(a1_if.rvalid) + int'(b1_if.rvalid);
            we_cnt   += int'(bram0_en && bram0_we);
            idle_cnt += int'(!bram0_en && !bram0_we);
            tick();
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        chk("wonly_no_rvalid", rv_cnt, 0);
        chk("wonly_we_cycles", we_cnt, 8);
        chk("wonly_idle_cycles", idle_cnt, 2);

        // Reset mid-read with the pipelined instance.
        set_a(1, 0, 3, 0);
        @(negedge clk); chk("midrst_rd_gnt", a1_if.gnt, 1);
        tick();
        set_a(1, 0, 4, 0);
        rst = 1'b1;
        @(negedge clk); chk("midrst_during", {a1_if.gnt, a1_if.rvalid, bram1_en}, 3'b000);
        tick();
        @(negedge clk); chk("midrst_n2_no_rvalid", {a1_if.rvalid, b1_if.rvalid, a0_if.rvalid}, 3'b000);
        tick();
        rst = 1'b0;
        set_a(0, 0, 0, 0);
        tick(); tick();

        // Randomized traffic; an ungranted command is held until accepted.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            ga = a0_if.gnt;
            gb = b0_if.gnt;
            tick();
            if (!a_req || ga) set_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            if (!b_req || gb) set_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
